// File: rtl/stream_ready_sink_pkg.sv
// Shared types and helpers for stream_ready_sink: FSM state encoding, delay width, LFSR step.
package stream_ready_sink_pkg;

  typedef enum logic [1:0] {Idle, Wait, Open} state_e;

  localparam int DelayWidth = 4;

  // 16-bit Fibonacci LFSR (taps 16,14,13,11); an all-zero state is kicked out by forcing a 1 in
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10] ^ (s == 16'h0);
    return {s[14:0], fb};
  endfunction

endpackage

// File: rtl/stream_ready_sink_checker.sv
// Upstream protocol checker: flags valid dropping or payload changing while stalled.
// Compiled only when STREAM_READY_SINK_CHECK_EN is defined.
`ifdef STREAM_READY_SINK_CHECK_EN
module stream_ready_sink_checker
  import stream_ready_sink_pkg::*;
#(
  parameter type payload_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clr_i,
  input  logic     valid_i,
  input  logic     ready_i,
  input  payload_t payload_i,
  output logic     err_o
);

  logic     stall_reg;
  payload_t payload_reg;
  logic     err_reg;
  logic     violation;

  assign violation = stall_reg && (!valid_i || (payload_i != payload_reg));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_reg   <= 1'b0;
      payload_reg <= '0;
      err_reg     <= 1'b0;
    end else if (clr_i) begin
      stall_reg   <= 1'b0;
      payload_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      stall_reg   <= valid_i && !ready_i;
      payload_reg <= payload_i;
      if (violation) err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;

endmodule
`endif

// File: rtl/stream_ready_sink.sv
// Valid/ready stream terminator with fixed or LFSR-random per-beat ready delay.
// Define STREAM_READY_SINK_CHECK_EN to instantiate the upstream protocol checker (err_o).
module stream_ready_sink
  import stream_ready_sink_pkg::*;
#(
  parameter bit          StallRandom = 1'b0,
  parameter int          FixedDelay  = 1,
  parameter type         payload_t   = logic,
  parameter logic [15:0] Seed        = 16'h0,
  parameter int          CountWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  payload_t              payload_i,
  output logic                  ready_o,
  output logic                  beat_o,
  output payload_t              payload_o,
  output logic [CountWidth-1:0] count_o,
  output logic                  err_o
);

  if (FixedDelay < 0 || FixedDelay > 15) begin : g_bad_delay
    $fatal(1, "stream_ready_sink: FixedDelay %0d outside 0..15", FixedDelay);
  end

  localparam logic [DelayWidth-1:0] FixedD = DelayWidth'(FixedDelay);

  state_e                  state_reg;
  logic [DelayWidth-1:0]   cnt_reg;
  logic [15:0]             lfsr_reg;
  payload_t                payload_reg;
  logic [CountWidth-1:0]   count_reg;
  logic [DelayWidth-1:0]   d_load;
  logic                    ready;
  logic                    beat;

  assign d_load = StallRandom ? lfsr_reg[DelayWidth-1:0] : FixedD;

  // Zero delay accepts in Idle in the same cycle valid is seen
  assign ready = en_i && ((state_reg == Open) ||
                          ((state_reg == Idle) && valid_i && (d_load == '0)));
  assign beat  = valid_i && ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= Idle;
      cnt_reg     <= '0;
      lfsr_reg    <= Seed;
      payload_reg <= '0;
      count_reg   <= '0;
    end else if (clr_i) begin
      state_reg   <= Idle;
      cnt_reg     <= '0;
      lfsr_reg    <= Seed;
      payload_reg <= '0;
      count_reg   <= '0;
    end else if (en_i) begin
      if (beat) begin
        payload_reg <= payload_i;
        count_reg   <= count_reg + CountWidth'(1);
      end
      case (state_reg)
        Idle: begin
          if (valid_i) begin
            lfsr_reg <= lfsr_next(lfsr_reg);
            if (d_load == DelayWidth'(1)) begin
              state_reg <= Open;
            end else if (d_load > DelayWidth'(1)) begin
              state_reg <= Wait;
              cnt_reg   <= d_load - DelayWidth'(1);
            end
          end
        end
        Wait: begin
          if (cnt_reg == DelayWidth'(1)) state_reg <= Open;
          else cnt_reg <= cnt_reg - DelayWidth'(1);
        end
        Open: begin
          if (valid_i) state_reg <= Idle;
        end
        default: state_reg <= Idle;
      endcase
    end
  end

  assign ready_o   = ready;
  assign beat_o    = beat;
  assign payload_o = payload_reg;
  assign count_o   = count_reg;

`ifdef STREAM_READY_SINK_CHECK_EN
  stream_ready_sink_checker #(
    .payload_t(payload_t)
  ) u_checker (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .valid_i  (valid_i),
    .ready_i  (ready),
    .payload_i(payload_i),
    .err_o    (err_o)
  );
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_ready_sink.sv
// Directed bench for stream_ready_sink: several configurations share one input stream,
// each step checks the instance under test with immediate assertions.
module tb_stream_ready_sink;

`ifdef STREAM_READY_SINK_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic       clk, rst_n, clr, en, valid;
  logic [7:0] payload;

  logic r3, b3, e3, r0, b0, e0, rr, br, er, r4, b4, e4, r5, b5, e5;
  logic [7:0]  p3, p0, pr, p4, p5;
  logic [31:0] c3, cr, c4, c5;
  logic [3:0]  c0;

  int checks = 0;
  int errors = 0;
  int dl[2][100];

  stream_ready_sink #(.FixedDelay(3), .payload_t(logic [7:0])) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .valid_i(valid), .payload_i(payload),
    .ready_o(r3), .beat_o(b3), .payload_o(p3), .count_o(c3), .err_o(e3));
  stream_ready_sink #(.FixedDelay(0), .payload_t(logic [7:0]), .CountWidth(4)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .valid_i(valid), .payload_i(payload),
    .ready_o(r0), .beat_o(b0), .payload_o(p0), .count_o(c0), .err_o(e0));
  stream_ready_sink #(.StallRandom(1'b1), .Seed(16'hACE1), .payload_t(logic [7:0])) u_rnd (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .valid_i(valid), .payload_i(payload),
    .ready_o(rr), .beat_o(br), .payload_o(pr), .count_o(cr), .err_o(er));
  stream_ready_sink #(.FixedDelay(4), .payload_t(logic [7:0])) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .valid_i(valid), .payload_i(payload),
    .ready_o(r4), .beat_o(b4), .payload_o(p4), .count_o(c4), .err_o(e4));
  stream_ready_sink #(.FixedDelay(5), .payload_t(logic [7:0])) u_d5 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .valid_i(valid), .payload_i(payload),
    .ready_o(r5), .beat_o(b5), .payload_o(p5), .count_o(c5), .err_o(e5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1 later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    cyc();
    clr   = 1'b1;
    valid = 1'b0;
    cyc();
    clr   = 1'b0;
  endtask

  initial begin
    int d, dmin, dmax;
    rst_n = 1'b1; clr = 1'b0; en = 1'b1; valid = 1'b0; payload = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", r3, 0);
    chk("rst_count", c3, 0);
    chk("rst_payload", p3, 0);
    chk("rst_err", e5, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // FixedDelay=3: accept in cycle 3, registered outputs from cycle 4
    do_clr();
    cyc(); valid = 1'b1; payload = 8'hA5; #1;
    chk("t1_ready_c0", r3, 0);
    for (int k = 1; k < 3; k++) begin
      cyc(); #1;
      chk("t1_ready_wait", r3, 0);
    end
    cyc(); #1;
    chk("t1_ready_c3", r3, 1);
    chk("t1_beat_c3", b3, 1);
    chk("t1_count_c3", c3, 0);
    cyc(); valid = 1'b0; #1;
    chk("t1_payload_c4", p3, 8'hA5);
    chk("t1_count_c4", c3, 1);
    chk("t1_ready_c4", r3, 0);
    $display("t1 fixed3 beat: payload=%0h count=%0d", p3, c3);

    // FixedDelay=0: same-cycle accept, then wrap of a 4-bit counter after 16 beats
    do_clr();
    for (int i = 0; i < 8; i++) begin
      cyc(); valid = 1'b1; payload = 8'h10 + 8'(i); #1;
      chk("t2_ready_eq_valid", r0, 1);
      chk("t2_beat", b0, 1);
    end
    cyc(); valid = 1'b0; #1;
    chk("t2_ready_idle", r0, 0);
    chk("t2_beat_idle", b0, 0);
    chk("t2_count8", c0, 8);
    chk("t2_payload", p0, 8'h17);
    for (int i = 0; i < 8; i++) begin
      cyc(); valid = 1'b1; payload = 8'(i); #1;
      chk("t2_beat2", b0, 1);
    end
    cyc(); valid = 1'b0; #1;
    chk("t2_count_wrap", c0, 0);
    chk("t2_payload2", p0, 8'h07);
    $display("t2 fixed0: count=%0d payload=%0h", c0, p0);

    // Random delays: 100 beats, two runs from the same seed
    for (int r = 0; r < 2; r++) begin
      do_clr();
      for (int b = 0; b < 100; b++) begin
        cyc(); valid = 1'b1; payload = 8'(b); #1;
        d = 0;
        while (!br && d < 20) begin
          cyc(); #1;
          d++;
        end
        chk("t3_delay_le15", 32'(d <= 15), 1);
        dl[r][b] = d;
      end
      cyc(); valid = 1'b0; #1;
      chk("t3_count100", cr, 100);
      chk("t3_payload_last", pr, 8'd99);
      $display("t3 random run %0d: count=%0d", r, cr);
    end
    dmin = 99; dmax = -1;
    for (int b = 0; b < 100; b++) begin
      chk("t3_repeatable", dl[1][b], dl[0][b]);
      if (dl[0][b] < dmin) dmin = dl[0][b];
      if (dl[0][b] > dmax) dmax = dl[0][b];
    end
    chk("t3_delays_vary", 32'(dmax > dmin), 1);

    // FixedDelay=4 with en low for cycles 1..5: handshake moves to cycle 9
    do_clr();
    cyc(); valid = 1'b1; payload = 8'h3C; #1;
    chk("t4_ready_c0", r4, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); en = 1'b0; #1;
      chk("t4_ready_paused", r4, 0);
    end
    for (int k = 6; k <= 8; k++) begin
      cyc(); en = 1'b1; #1;
      chk("t4_ready_resumed", r4, 0);
    end
    cyc(); #1;
    chk("t4_beat_c9", b4, 1);
    cyc(); valid = 1'b0; #1;
    chk("t4_count", c4, 1);
    chk("t4_payload", p4, 8'h3C);
    $display("t4 enable pause: count=%0d payload=%0h", c4, p4);

    // clr in Wait after two beats restarts the full delay
    do_clr();
    for (int n = 0; n < 2; n++) begin
      cyc(); valid = 1'b1; payload = 8'h40 + 8'(n); #1;
      repeat (3) cyc();
      #1;
      chk("t5_beat", b3, 1);
    end
    cyc(); payload = 8'h50; #1;
    chk("t5_count2", c3, 2);
    chk("t5_payload41", p3, 8'h41);
    cyc(); clr = 1'b1; #1;
    cyc(); clr = 1'b0; #1;
    chk("t5_count_clr", c3, 0);
    chk("t5_payload_clr", p3, 0);
    chk("t5_ready_c2", r3, 0);
    for (int k = 3; k <= 4; k++) begin
      cyc(); #1;
      chk("t5_ready_wait", r3, 0);
    end
    cyc(); #1;
    chk("t5_beat_c5", b3, 1);
    cyc(); valid = 1'b0; #1;
    chk("t5_count1", c3, 1);
    chk("t5_payload50", p3, 8'h50);
    $display("t5 clear in wait: count=%0d payload=%0h", c3, p3);

    // Payload changes in cycle 2 while stalled: err from cycle 3 (checker builds only)
    do_clr();
    cyc(); valid = 1'b1; payload = 8'h11; #1;
    chk("t6_err_c0", e5, 0);
    cyc(); #1;
    chk("t6_err_c1", e5, 0);
    cyc(); payload = 8'h22; #1;
    chk("t6_err_c2", e5, 0);
    cyc(); #1;
    chk("t6_err_c3", e5, 32'(ChkEn));
    cyc(); #1;
    chk("t6_err_c4", e5, 32'(ChkEn));
    cyc(); #1;
    chk("t6_beat_c5", b5, 1);
    cyc(); valid = 1'b0; #1;
    chk("t6_payload", p5, 8'h22);
    repeat (3) cyc();
    #1;
    chk("t6_err_sticky", e5, 32'(ChkEn));
    do_clr();
    #1;
    chk("t6_err_cleared", e5, 0);
    $display("t6 checker: err=%0b after clear", e5);

    // Async reset mid-Wait: back to Idle, full delay after release
    do_clr();
    cyc(); valid = 1'b1; payload = 8'h66; #1;
    cyc(); #1;
    rst_n = 1'b0; #1;
    chk("t7_ready_rst", r3, 0);
    cyc(); rst_n = 1'b1; #1;
    chk("t7_ready_c2", r3, 0);
    for (int k = 3; k <= 4; k++) begin
      cyc(); #1;
      chk("t7_ready_wait", r3, 0);
    end
    cyc(); #1;
    chk("t7_beat_c5", b3, 1);
    cyc(); valid = 1'b0; #1;
    chk("t7_count", c3, 1);
    $display("t7 reset in wait: count=%0d", c3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
